// File: rtl/value_stack_pkg.sv
// Shared op/trap encodings and the per-op depth requirement table for the
// operand stack; the CPU decoder imports the same package.
package value_stack_pkg;

    localparam logic [2:0] STACK_NOP     = 3'd0;
    localparam logic [2:0] STACK_PUSH    = 3'd1;
    localparam logic [2:0] STACK_POP     = 3'd2;
    localparam logic [2:0] STACK_UNARY   = 3'd3;
    localparam logic [2:0] STACK_BINARY  = 3'd4;
    localparam logic [2:0] STACK_SELECT  = 3'd5;
    localparam logic [2:0] STACK_DUP     = 3'd6;
    localparam logic [2:0] STACK_ILLEGAL = 3'd7;

    localparam logic [3:0] TRAP_NONE      = 4'd0;
    localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
    localparam logic [3:0] TRAP_OVERFLOW  = 4'd2;
    localparam logic [3:0] TRAP_ILLEGAL   = 4'd3;

    // min_depth: entries that must exist before the op; grows: op adds one entry.
    typedef struct packed {
        logic [2:0] min_depth;
        logic       grows;
    } op_req_t;

    function automatic op_req_t op_req(input logic [2:0] op);
        op_req_t r;
        r = '{min_depth: 3'd0, grows: 1'b0};
        case (op)
            STACK_PUSH:   r = '{min_depth: 3'd0, grows: 1'b1};
            STACK_POP:    r = '{min_depth: 3'd1, grows: 1'b0};
            STACK_UNARY:  r = '{min_depth: 3'd1, grows: 1'b0};
            STACK_BINARY: r = '{min_depth: 3'd2, grows: 1'b0};
            STACK_SELECT: r = '{min_depth: 3'd3, grows: 1'b0};
            STACK_DUP:    r = '{min_depth: 3'd1, grows: 1'b1};
            default:      r = '{min_depth: 3'd0, grows: 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH storage for the operand stack: one synchronous write port
// and two asynchronous read ports used to refill nos after a depth decrease.
module stack_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: nothing is read back above the live depth.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/value_stack.sv
// WebAssembly operand stack: depth counter, registered tos/nos, legality
// check and sticky trap register around a stack_ram of DEPTH entries.
module value_stack
    import value_stack_pkg::*;
#(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 16,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    // op_valid is a single-cycle strobe with no ready: every cycle it is
    // sampled high consumes exactly one op, and results are visible next cycle.
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic [3:0]       trap
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [3:0]       trap_q, trap_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a, raddr_b;
    logic [WIDTH-1:0] rdata_a, rdata_b;
    op_req_t          req;
    logic [DW-1:0]    need;

    // Refill sources: entry depth-3 after a net -1, entry depth-4 after a net -2.
    assign raddr_a = AW'(depth_q - DW'(3));
    assign raddr_b = AW'(depth_q - DW'(4));

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    assign req  = op_req(op);
    assign need = {{(DW-3){1'b0}}, req.min_depth};

    always_comb begin
        depth_d = depth_q;
        tos_d   = tos_q;
        nos_d   = nos_q;
        trap_d  = trap_q;
        we      = 1'b0;
        waddr   = AW'(depth_q);
        wdata   = push_data;
        if (op_valid && trap_q == TRAP_NONE) begin
            if (op == STACK_ILLEGAL) begin
                trap_d = TRAP_ILLEGAL;
            end else if (depth_q < need) begin
                trap_d = TRAP_UNDERFLOW;
            end else if (req.grows && depth_q == DW'(DEPTH)) begin
                trap_d = TRAP_OVERFLOW;
            end else begin
                case (op)
                    STACK_PUSH: begin
                        we      = 1'b1;
                        tos_d   = push_data;
                        nos_d   = tos_q;
                        depth_d = depth_q + DW'(1);
                    end
                    STACK_POP: begin
                        tos_d   = nos_q;
                        nos_d   = (depth_q >= DW'(3)) ? rdata_a : '0;
                        depth_d = depth_q - DW'(1);
                    end
                    STACK_UNARY: begin
                        we    = 1'b1;
                        waddr = AW'(depth_q - DW'(1));
                        tos_d = push_data;
                    end
                    STACK_BINARY: begin
                        we      = 1'b1;
                        waddr   = AW'(depth_q - DW'(2));
                        tos_d   = push_data;
                        nos_d   = (depth_q >= DW'(3)) ? rdata_a : '0;
                        depth_d = depth_q - DW'(1);
                    end
                    STACK_SELECT: begin
                        we      = 1'b1;
                        waddr   = AW'(depth_q - DW'(3));
                        tos_d   = push_data;
                        nos_d   = (depth_q >= DW'(4)) ? rdata_b : '0;
                        depth_d = depth_q - DW'(2);
                    end
                    STACK_DUP: begin
                        we      = 1'b1;
                        wdata   = tos_q;
                        nos_d   = tos_q;
                        depth_d = depth_q + DW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            depth_q <= depth_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            trap_q  <= trap_d;
        end
    end

    assign tos   = tos_q;
    assign nos   = nos_q;
    assign depth = depth_q;
    assign empty = (depth_q == '0);
    assign full  = (depth_q == DW'(DEPTH));
    assign trap  = trap_q;

endmodule

// File: tb/tb_value_stack.sv
// Self-checking bench for value_stack: constant vector table, hand-written
// corner sequences and a queue-model random phase feeding one scoreboard.
module tb_value_stack;

    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int EW    = 2 * WIDTH + DW + 4;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, UNARY = 3'd3,
                           BINARY = 3'd4, SELECT = 3'd5, DUP = 3'd6, ILL = 3'd7;

    logic             clk;
    logic             reset;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] tos, nos;
    logic [DW-1:0]    depth;
    logic             empty, full;
    logic [3:0]       trap;

    int checks;
    int errors;

    logic [EW-1:0]    exp_q[$];
    logic [WIDTH-1:0] mstk[$];
    logic [3:0]       mtrap;

    value_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .push_data (push_data),
        .tos       (tos),
        .nos       (nos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .trap      (trap)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] n,
                                           input int d, input logic [3:0] tr);
        return {t, n, DW'(d), tr};
    endfunction

    task automatic compare(input string tag, input logic [EW-1:0] e);
        logic [WIDTH-1:0] et, en;
        logic [DW-1:0]    ed;
        logic [3:0]       etr;
        {et, en, ed, etr} = e;
        chk({tag, ".tos"},   tos, et);
        chk({tag, ".nos"},   nos, en);
        chk({tag, ".depth"}, WIDTH'(depth), WIDTH'(ed));
        chk({tag, ".empty"}, WIDTH'(empty), WIDTH'(ed == '0));
        chk({tag, ".full"},  WIDTH'(full),  WIDTH'(ed == DW'(DEPTH)));
        chk({tag, ".trap"},  WIDTH'(trap),  WIDTH'(etr));
    endtask

    // Asserts reset mid-cycle, checks outputs before any further clock edge,
    // releases on a falling edge.
    task automatic do_reset(input string tag);
        op_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        compare(tag, pack('0, '0, 0, 4'd0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mstk.delete();
        mtrap = 4'd0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic v, input logic [2:0] o,
                        input logic [WIDTH-1:0] d, input logic [EW-1:0] e);
        @(negedge clk);
        op_valid  = v;
        op        = o;
        push_data = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
        end else begin
            compare(tag, exp_q.pop_front());
        end
    endtask

    // Reference: a plain queue treated as the stack, back = top.
    task automatic model_step(input string tag, input logic v, input logic [2:0] o,
                              input logic [WIDTH-1:0] d);
        int n;
        logic [WIDTH-1:0] et, en;
        n = mstk.size();
        if (v && mtrap == 4'd0) begin
            case (o)
                PUSH:   if (n >= DEPTH) mtrap = 4'd2; else mstk.push_back(d);
                POP:    if (n < 1) mtrap = 4'd1; else void'(mstk.pop_back());
                UNARY:  if (n < 1) mtrap = 4'd1; else begin void'(mstk.pop_back()); mstk.push_back(d); end
                BINARY: if (n < 2) mtrap = 4'd1;
                        else begin void'(mstk.pop_back()); void'(mstk.pop_back()); mstk.push_back(d); end
                SELECT: if (n < 3) mtrap = 4'd1;
                        else begin
                            void'(mstk.pop_back()); void'(mstk.pop_back()); void'(mstk.pop_back());
                            mstk.push_back(d);
                        end
                DUP:    if (n < 1) mtrap = 4'd1;
                        else if (n >= DEPTH) mtrap = 4'd2;
                        else mstk.push_back(mstk[n-1]);
                ILL:    mtrap = 4'd3;
                default: ;
            endcase
        end
        n  = mstk.size();
        et = (n > 0) ? mstk[n-1] : '0;
        en = (n > 1) ? mstk[n-2] : '0;
        step(tag, v, o, d, pack(et, en, n, mtrap));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             v;
        logic [2:0]       o;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] n;
        int               dep;
        logic [3:0]       tr;
    } vec_t;

    vec_t tbl[14];

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        op_valid  = 1'b0;
        op        = NOP;
        push_data = '0;
        mtrap     = 4'd0;

        tbl[0]  = '{1'b1, PUSH,   64'h0,  64'h0, 64'h0, 1, 4'd0};
        tbl[1]  = '{1'b1, UNARY,  64'h1,  64'h1, 64'h0, 1, 4'd0};
        tbl[2]  = '{1'b1, POP,    64'h99, 64'h0, 64'h0, 0, 4'd0};
        tbl[3]  = '{1'b1, PUSH,   64'h5,  64'h5, 64'h0, 1, 4'd0};
        tbl[4]  = '{1'b1, PUSH,   64'h7,  64'h7, 64'h5, 2, 4'd0};
        tbl[5]  = '{1'b1, BINARY, 64'hC,  64'hC, 64'h0, 1, 4'd0};
        tbl[6]  = '{1'b1, POP,    64'h0,  64'h0, 64'h0, 0, 4'd0};
        tbl[7]  = '{1'b1, PUSH,   64'hA,  64'hA, 64'h0, 1, 4'd0};
        tbl[8]  = '{1'b1, PUSH,   64'hB,  64'hB, 64'hA, 2, 4'd0};
        tbl[9]  = '{1'b1, PUSH,   64'hC,  64'hC, 64'hB, 3, 4'd0};
        tbl[10] = '{1'b1, SELECT, 64'hB,  64'hB, 64'h0, 1, 4'd0};
        tbl[11] = '{1'b1, PUSH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hB, 2, 4'd0};
        tbl[12] = '{1'b0, PUSH,   64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 64'hB, 2, 4'd0};
        tbl[13] = '{1'b1, NOP,    64'h66, 64'hFFFF_FFFF_FFFF_FFFF, 64'hB, 2, 4'd0};

        #2;
        compare("reset", pack('0, '0, 0, 4'd0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].o, tbl[i].d,
                 pack(tbl[i].t, tbl[i].n, tbl[i].dep, tbl[i].tr));
        end

        // Fill to full, overflow, then everything is ignored.
        do_reset("rst_fill");
        for (int i = 1; i <= DEPTH; i++) begin
            step($sformatf("fill%0d", i), 1'b1, PUSH, WIDTH'(i), pack(WIDTH'(i), WIDTH'(i - 1), i, 4'd0));
        end
        step("ovf_push", 1'b1, PUSH, 64'h77, pack(64'd16, 64'd15, 16, 4'd2));
        step("ovf_pop",  1'b1, POP,  64'h0,  pack(64'd16, 64'd15, 16, 4'd2));

        // DUP at full overflows.
        do_reset("rst_dupfull");
        for (int i = 1; i <= DEPTH; i++) begin
            step($sformatf("dfill%0d", i), 1'b1, PUSH, WIDTH'(100 + i),
                 pack(WIDTH'(100 + i), (i > 1) ? WIDTH'(99 + i) : '0, i, 4'd0));
        end
        step("dup_full", 1'b1, DUP, 64'h0, pack(64'd116, 64'd115, 16, 4'd2));

        // Deep refill paths.
        do_reset("rst_deep");
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("deep%0d", i), 1'b1, PUSH, WIDTH'(i), pack(WIDTH'(i), WIDTH'(i - 1), i, 4'd0));
        end
        step("deep_sel", 1'b1, SELECT, 64'h8, pack(64'h8, 64'h2, 3, 4'd0));
        step("deep_bin", 1'b1, BINARY, 64'h9, pack(64'h9, 64'h1, 2, 4'd0));
        step("deep_pop", 1'b1, POP,    64'h0, pack(64'h1, 64'h0, 1, 4'd0));

        // Underflow, mid-stream reset, illegal op, first trap wins.
        do_reset("rst_unf");
        step("unf_push", 1'b1, PUSH,   64'h3, pack(64'h3, 64'h0, 1, 4'd0));
        step("unf_bin",  1'b1, BINARY, 64'h4, pack(64'h3, 64'h0, 1, 4'd1));
        step("unf_ill",  1'b1, ILL,    64'h0, pack(64'h3, 64'h0, 1, 4'd1));
        step("unf_psh2", 1'b1, PUSH,   64'h6, pack(64'h3, 64'h0, 1, 4'd1));
        step("mid_push", 1'b0, PUSH,   64'h6, pack(64'h3, 64'h0, 1, 4'd1));
        do_reset("rst_mid");
        step("ill_op",   1'b1, ILL,    64'h0, pack(64'h0, 64'h0, 0, 4'd3));
        step("ill_push", 1'b1, PUSH,   64'h1, pack(64'h0, 64'h0, 0, 4'd3));

        do_reset("rst_dup0");
        step("dup0",     1'b1, DUP,    64'h0, pack(64'h0, 64'h0, 0, 4'd1));
        do_reset("rst_dup");
        step("dup_push", 1'b1, PUSH,   64'h9, pack(64'h9, 64'h0, 1, 4'd0));
        step("dup",      1'b1, DUP,    64'h0, pack(64'h9, 64'h9, 2, 4'd0));
        step("sel_unf",  1'b1, SELECT, 64'h1, pack(64'h9, 64'h9, 2, 4'd1));
        do_reset("rst_un0");
        step("unary0",   1'b1, UNARY,  64'h1, pack(64'h0, 64'h0, 0, 4'd1));

        // Random phase against the queue model; reset whenever a trap sticks.
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            logic [2:0] o;
            logic       v;
            int         r;
            r = $urandom_range(0, 99);
            if (r < 35)      o = PUSH;
            else if (r < 98) o = 3'($urandom_range(0, 6));
            else             o = ILL;
            v = ($urandom_range(0, 9) != 0);
            model_step($sformatf("rnd%0d", i), v, o, {$urandom, $urandom});
            if (mtrap != 4'd0) do_reset($sformatf("rst_rnd%0d", i));
        end

        chk("scoreboard_drained", WIDTH'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
